// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
//   Shared definitions for the sequential shift-add multiplier:
//   the controller state enumeration and the default operand width.
package seq_mult_pkg;

  // Operand width used when the instantiating level does not override it.
  localparam int DEFAULT_WIDTH = 16;

  // Controller states: wait for operands, iterate, finalise sign, hold result.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage : seq_mult_pkg

// File: rtl/seq_mult_step.sv
// seq_mult_step
//   One iteration of the shift-add multiply, purely combinational.
//   If the accumulator LSB is set, the multiplicand is added to the upper
//   half with the carry kept, then {carry, accumulator} is shifted right by one.
// Ports
//   i_acc    [2*WIDTH-1:0]  accumulator before the iteration
//   i_mcand  [WIDTH-1:0]    multiplicand magnitude
//   o_acc    [2*WIDTH-1:0]  accumulator after the iteration
module seq_mult_step #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_sum;

  assign w_addend = i_acc[0] ? {1'b0, i_mcand} : '0;
  assign w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + w_addend;

  // The carry becomes the new MSB; the old bit 0 (already consumed) drops out.
  assign o_acc = {w_sum, i_acc[WIDTH-1:1]};

endmodule : seq_mult_step

// File: rtl/seq_mult.sv
// seq_mult
//   Sequential WIDTH x WIDTH multiplier (signed or unsigned) with valid/ready
//   handshakes on both sides. Operands are converted to magnitudes on accept,
//   multiplied by WIDTH shift-add iterations, and the sign is applied once in
//   the FINAL state.
// Ports
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_start_valid   operands and mode present
//   o_start_ready   block can accept operands (IDLE only)
//   i_is_signed     1 = two's-complement operands, 0 = unsigned
//   i_multiplicand  operand A
//   i_multiplier    operand B
//   o_prod_valid    product available (DONE only)
//   i_prod_ready    consumer takes product
//   o_product       registered 2*WIDTH-bit result
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start_valid,
  output logic               o_start_ready,
  input  logic               i_is_signed,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_prod_valid,
  input  logic               i_prod_ready,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t               r_state;
  state_t               w_state_next;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_mcand;
  logic                 r_sign;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic                 w_last;

  // Absolute value as an unsigned WIDTH-bit number; the most negative value
  // maps to 2^(WIDTH-1), which still fits because the result is unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             s);
    return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  assign w_mag_a = magnitude(i_multiplicand, i_is_signed);
  assign w_mag_b = magnitude(i_multiplier, i_is_signed);
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  seq_mult_step #(.WIDTH(WIDTH)) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .o_acc   (w_acc_step)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; BUSY length depends only on the counter, never on data.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start_valid) w_state_next = S_BUSY;
      S_BUSY:  if (w_last)        w_state_next = S_FINAL;
      S_FINAL:                    w_state_next = S_DONE;
      S_DONE:  if (i_prod_ready)  w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_sign    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start_valid) begin
            r_mcand <= w_mag_a;
            r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
            r_cnt   <= '0;
            r_sign  <= i_is_signed &
                       (i_multiplicand[WIDTH-1] ^ i_multiplier[WIDTH-1]);
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FINAL: begin
          r_product <= r_sign ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
        end
        default: ;
      endcase
    end
  end

  assign o_start_ready = (r_state == S_IDLE);
  assign o_prod_valid  = (r_state == S_DONE);
  assign o_product     = r_product;

endmodule : seq_mult

// File: tb/tb_seq_mult.sv
// tb_seq_mult
//   Self-checking bench for seq_mult (WIDTH=16): a transaction-level model
//   predicts ready/valid/product every cycle, and directed vectors carry
//   hand-computed products.
module tb_seq_mult;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           start_valid;
  logic           start_ready;
  logic           is_signed;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           prod_valid;
  logic           prod_ready;
  logic [2*W-1:0] product;

  int n_pass   = 0;
  int n_checks = 0;

  seq_mult #(.WIDTH(W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start_valid  (start_valid),
    .o_start_ready  (start_ready),
    .i_is_signed    (is_signed),
    .i_multiplicand (mcand),
    .i_multiplier   (mplier),
    .o_prod_valid   (prod_valid),
    .i_prod_ready   (prod_ready),
    .o_product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
  endtask

  // Arithmetic reference product.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic s);
    longint pa, pb;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    return (2*W)'(pa * pb);
  endfunction

  // Transaction model: accept in idle, result appears 17 edges after the
  // accept edge (the 18th edge counting the accept edge itself), held until
  // taken, idle again on the edge after the handshake.
  logic           m_ready;
  logic           m_valid;
  logic [2*W-1:0] m_product;
  logic [2*W-1:0] m_pending;
  int             m_lat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready   <= 1'b1;
      m_valid   <= 1'b0;
      m_product <= '0;
      m_pending <= '0;
      m_lat     <= 0;
    end else if (m_valid) begin
      if (prod_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end else if (m_ready) begin
      if (start_valid) begin
        m_ready   <= 1'b0;
        m_lat     <= 17;
        m_pending <= ref_prod(mcand, mplier, is_signed);
      end
    end else if (m_lat > 0) begin
      m_lat <= m_lat - 1;
      if (m_lat == 1) begin
        m_valid   <= 1'b1;
        m_product <= m_pending;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_start_ready", 64'(start_ready), 64'(m_ready));
      check("cyc_prod_valid", 64'(prod_valid), 64'(m_valid));
      check("cyc_product", 64'(product), 64'(m_product));
    end
  end

  // Caller stands at posedge+1 just after the accept edge.
  task automatic wait_product(input string name, input logic [2*W-1:0] want);
    int n;
    n = 0;
    while (!prod_valid && n <= 40) begin
      @(posedge clk); #1;
      n++;
      mcand  = W'($urandom);
      mplier = W'($urandom);
    end
    check({name, "_latency"}, 64'(n), 64'd17);
    check(name, 64'(product), 64'(want));
    $display("txn %s product=%h edges=%0d", name, product, n);
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
    mcand       = a;
    mplier      = b;
    is_signed   = s;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] want);
    accept(a, b, s);
    wait_product(name, want);
    @(posedge clk); #1;
    check({name, "_ready_after"}, 64'(start_ready), 64'd1);
    check({name, "_valid_drop"}, 64'(prod_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout global bound expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    is_signed   = 1'b0;
    mcand       = '0;
    mplier      = '0;
    prod_ready  = 1'b1;
    #3;
    check("rst_start_ready", 64'(start_ready), 64'd1);
    check("rst_prod_valid", 64'(prod_valid), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    #9 rst_n = 1'b1;
    #4;  // now at posedge+1

    run_op("u_3x5",        16'h0003, 16'h0005, 1'b0, 32'h0000000F);
    run_op("s_m3x5",       16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1);
    run_op("s_m1xm1",      16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    run_op("s_min_x_min",  16'h8000, 16'h8000, 1'b1, 32'h40000000);
    run_op("s_max_x_min",  16'h7FFF, 16'h8000, 1'b1, 32'hC0008000);
    run_op("u_ffff_ffff",  16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    run_op("u_8000x2",     16'h8000, 16'h0002, 1'b0, 32'h00010000);
    run_op("u_zero",       16'h0000, 16'h1234, 1'b0, 32'h00000000);

    // Back-pressure: hold result, ignore new start requests.
    prod_ready = 1'b0;
    accept(16'h1234, 16'h0010, 1'b0);
    wait_product("u_hold", 32'h00012340);
    for (int i = 0; i < 10; i++) begin
      start_valid = i[0];
      mcand       = W'($urandom);
      mplier      = W'($urandom);
      is_signed   = 1'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 64'(prod_valid), 64'd1);
      check("hold_product", 64'(product), 64'h00012340);
    end
    start_valid = 1'b0;
    prod_ready  = 1'b1;
    @(posedge clk); #1;
    check("hold_ready_after", 64'(start_ready), 64'd1);
    check("hold_valid_drop", 64'(prod_valid), 64'd0);
    check("hold_product_kept", 64'(product), 64'h00012340);
    $display("txn hold released product=%h", product);

    // Reset during BUSY aborts the operation.
    accept(16'h00FF, 16'h0101, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_prod_valid", 64'(prod_valid), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    check("abort_start_ready", 64'(start_ready), 64'd1);
    mcand       = 16'h0002;
    mplier      = 16'h0007;
    is_signed   = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    check("abort_in_reset_valid", 64'(prod_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;  // first edge after release accepts
    start_valid = 1'b0;
    check("restart_busy", 64'(start_ready), 64'd0);
    wait_product("u_2x7", 32'h0000000E);
    @(posedge clk); #1;
    check("u_2x7_ready_after", 64'(start_ready), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seq_mult
